// File: rtl/shared_port_arbiter.sv
// rtl/shared_port_arbiter.sv - shared register-update port arbiter for N requester lanes
//
// Purpose: grants one shared write port to one of N requester lanes. The owner
// keeps the port until it releases it (i_done, dropping its request, or the
// optional hold limit). On release the grant moves directly to the next winner
// on the same edge, so handoffs have no idle cycle. The policy is chosen at
// elaboration: round-robin (FIXED_PRIO=0) or lowest-index-wins (FIXED_PRIO=1).
//
// Optional feature macro: ARB_HOLD_LIMIT_EN
//   defined   - an 8-bit hold counter forces a release after MAX_HOLD owned
//               cycles and pulses o_timeout on that edge.
//   undefined - the owner holds indefinitely and o_timeout is tied 0.
//
// Ports:
//   i_clk         - clock, rising edge
//   i_rst         - synchronous active-low reset
//   i_req[N]      - per-lane level request
//   i_done        - current owner releases the port this cycle
//   o_grant[N]    - registered one-hot grant (or zero)
//   o_grant_valid - registered OR of o_grant
//   o_grant_idx   - index of the granted lane, 0 when none
//   o_timeout     - one-cycle pulse on a forced (hold-limit) release
module shared_port_arbiter #(
  parameter int N          = 4,
  parameter int FIXED_PRIO = 0,
  parameter int MAX_HOLD   = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N-1:0]         i_req,
  input  logic                 i_done,
  output logic [N-1:0]         o_grant,
  output logic                 o_grant_valid,
  output logic [$clog2(N)-1:0] o_grant_idx,
  output logic                 o_timeout
);

  localparam int IW = $clog2(N);

  // Parameter range checks at elaboration time.
  if (N < 2 || N > 16) begin : g_bad_n
    $error("shared_port_arbiter: N must be in 2..16");
  end
  if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
    $error("shared_port_arbiter: MAX_HOLD must be in 1..255");
  end

  typedef enum logic {S_IDLE = 1'b0, S_OWNED = 1'b1} state_t;

  state_t          r_state;
  state_t          w_next_state;
  logic [N-1:0]    w_grant;
  logic [N-1:0]    w_next_grant;
  logic [N-1:0]    w_cand;
  logic            r_grant_valid;
  logic [IW-1:0]   r_grant_idx;
  logic [IW-1:0]   w_next_idx;
  logic            w_owned;
  logic            w_owner_req;
  logic            w_hold_hit;
  logic            w_release;
  logic            w_keep;
  logic            w_issue;
  logic            w_win_found;
  logic [IW-1:0]   w_win_idx;

  assign w_owned     = (r_state == S_OWNED);
  assign w_owner_req = |(i_req & w_grant);
  assign w_release   = w_owned && (i_done || !w_owner_req || w_hold_hit);
  assign w_keep      = w_owned && !w_release;
  // A grant is issued from IDLE, or as a handoff on the release edge.
  assign w_issue     = (!w_owned || w_release) && w_win_found;

  // Per-lane candidate masking and grant flop. The current owner is masked
  // out of the candidate set, which only matters on its release edge.
  for (genvar k = 0; k < N; k++) begin : g_lane
    logic r_lane_grant;

    assign w_cand[k]       = i_req[k] & ~(w_owned & w_grant[k]);
    assign w_next_grant[k] = w_issue ? (w_win_idx == IW'(k)) : (w_keep & w_grant[k]);

    always_ff @(posedge i_clk) begin
      if (!i_rst) begin
        r_lane_grant <= 1'b0;
      end else begin
        r_lane_grant <= w_next_grant[k];
      end
    end

    assign w_grant[k] = r_lane_grant;
  end

  // Winner selection policy.
  if (FIXED_PRIO != 0) begin : g_fixed
    logic          w_fp_found;
    logic [IW-1:0] w_fp_idx;

    // Scan high to low so the last hit, the lowest index, wins.
    always_comb begin
      w_fp_found = 1'b0;
      w_fp_idx   = '0;
      for (int i = N - 1; i >= 0; i--) begin
        if (w_cand[i]) begin
          w_fp_found = 1'b1;
          w_fp_idx   = IW'(i);
        end
      end
    end

    assign w_win_found = w_fp_found;
    assign w_win_idx   = w_fp_idx;
  end else begin : g_rr
    logic [IW-1:0] r_ptr;
    logic          w_rr_found;
    logic [IW-1:0] w_rr_idx;

    // Search begins at r_ptr (last owner + 1) and wraps modulo N.
    always_comb begin
      int j;
      j          = 0;
      w_rr_found = 1'b0;
      w_rr_idx   = '0;
      for (int i = 0; i < N; i++) begin
        j = int'(r_ptr) + i;
        if (j >= N) j = j - N;
        if (!w_rr_found && w_cand[j]) begin
          w_rr_found = 1'b1;
          w_rr_idx   = j[IW-1:0];
        end
      end
    end

    // The pointer moves only when a grant is actually issued.
    always_ff @(posedge i_clk) begin
      if (!i_rst) begin
        r_ptr <= '0;
      end else if (w_issue) begin
        r_ptr <= (w_win_idx == IW'(N - 1)) ? '0 : w_win_idx + 1'b1;
      end
    end

    assign w_win_found = w_rr_found;
    assign w_win_idx   = w_rr_idx;
  end

`ifdef ARB_HOLD_LIMIT_EN
  logic [7:0] r_hold_cnt;
  logic       r_timeout;

  // The counter reads k-1 at the k-th owned edge, so the limit hits when the
  // owner has held exactly MAX_HOLD cycles.
  assign w_hold_hit = (r_hold_cnt == 8'(MAX_HOLD - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_hold_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_issue) begin
        r_hold_cnt <= '0;
      end else if (w_keep) begin
        r_hold_cnt <= r_hold_cnt + 8'd1;
      end
      // Only a release caused solely by the limit counts as a timeout.
      r_timeout <= w_owned && w_hold_hit && !i_done && w_owner_req;
    end
  end
`else
  assign w_hold_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state       <= S_IDLE;
      r_grant_valid <= 1'b0;
      r_grant_idx   <= '0;
    end else begin
      r_state       <= w_next_state;
      r_grant_valid <= w_issue | w_keep;
      r_grant_idx   <= w_next_idx;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    w_next_idx   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_win_found) w_next_state = S_OWNED;
      end
      S_OWNED: begin
        if (w_release && !w_win_found) w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
    if (w_issue) begin
      w_next_idx = w_win_idx;
    end else if (w_keep) begin
      w_next_idx = r_grant_idx;
    end
  end

  // Outputs.
  always_comb begin
    o_grant       = w_grant;
    o_grant_valid = r_grant_valid;
    o_grant_idx   = r_grant_idx;
`ifdef ARB_HOLD_LIMIT_EN
    o_timeout     = r_timeout;
`else
    o_timeout     = 1'b0;
`endif
  end

endmodule

// File: tb/tb_shared_port_arbiter.sv
// tb/tb_shared_port_arbiter.sv - directed self-checking bench for shared_port_arbiter
module tb_shared_port_arbiter;

  logic       clk;
  logic       rst_a, done_a, rst_b, done_b;
  logic [3:0] req_a, req_b;
  logic [3:0] grant_a, grant_b;
  logic       valid_a, valid_b, tmo_a, tmo_b;
  logic [1:0] idx_a, idx_b;
  int         passed, total;

  shared_port_arbiter #(.N(4), .FIXED_PRIO(0), .MAX_HOLD(8)) dut_rr (
    .i_clk(clk), .i_rst(rst_a), .i_req(req_a), .i_done(done_a),
    .o_grant(grant_a), .o_grant_valid(valid_a), .o_grant_idx(idx_a), .o_timeout(tmo_a)
  );

  shared_port_arbiter #(.N(4), .FIXED_PRIO(1), .MAX_HOLD(8)) dut_fp (
    .i_clk(clk), .i_rst(rst_b), .i_req(req_b), .i_done(done_b),
    .o_grant(grant_b), .o_grant_valid(valid_b), .o_grant_idx(idx_b), .o_timeout(tmo_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0; req_a = 4'b0; req_b = 4'b0; done_a = 1'b0; done_b = 1'b0;
    tick(); tick();
    total++;
    if ({grant_a, valid_a, idx_a, tmo_a} !== 8'b0) $display("FAIL reset_rr got=%b exp=%b", {grant_a, valid_a, idx_a, tmo_a}, 8'b0);
    else passed++;
    total++;
    if ({grant_b, valid_b, idx_b, tmo_b} !== 8'b0) $display("FAIL reset_fp got=%b exp=%b", {grant_b, valid_b, idx_b, tmo_b}, 8'b0);
    else passed++;
    rst_a = 1'b1; rst_b = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      total++;
      if ({grant_a, valid_a} !== 5'b0) $display("FAIL idle_no_req cyc=%0d got=%b exp=%b", c, {grant_a, valid_a}, 5'b0);
      else passed++;
    end
  endtask

  task automatic test_rr_rotation();
    int seq [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_g;
    req_a = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      done_a = (i > 0);
      tick();
      exp_g = 4'b0001 << seq[i];
      total++;
      if ({grant_a, valid_a, idx_a} !== {exp_g, 1'b1, 2'(seq[i])})
        $display("FAIL rr_handoff step=%0d got=%b/%0d exp=%b/%0d", i, grant_a, idx_a, exp_g, seq[i]);
      else passed++;
      done_a = 1'b0;
      tick();
      total++;
      if ({grant_a, valid_a} !== {exp_g, 1'b1})
        $display("FAIL rr_hold step=%0d got=%b exp=%b", i, grant_a, exp_g);
      else passed++;
    end
  endtask

  task automatic test_rr_wrap();
    // Owner is lane 0; move ownership to lane 3 first.
    req_a = 4'b1000; done_a = 1'b1;
    tick();
    total++;
    if ({grant_a, idx_a} !== {4'b1000, 2'd3}) $display("FAIL rr_to_lane3 got=%b/%0d exp=1000/3", grant_a, idx_a);
    else passed++;
    req_a = 4'b1001; done_a = 1'b1;
    tick();
    total++;
    if ({grant_a, valid_a, idx_a} !== {4'b0001, 1'b1, 2'd0}) $display("FAIL rr_wrap got=%b/%0d exp=0001/0", grant_a, idx_a);
    else passed++;
    done_a = 1'b0;
  endtask

  task automatic test_reset_mid();
    // Lane 0 owns with lane 3 still requesting; reset must drop the grant.
    rst_a = 1'b0;
    tick();
    total++;
    if ({grant_a, valid_a, idx_a} !== 7'b0) $display("FAIL reset_mid got=%b exp=0000000", {grant_a, valid_a, idx_a});
    else passed++;
    rst_a = 1'b1; req_a = 4'b0;
    tick();
    total++;
    if ({grant_a, valid_a} !== 5'b0) $display("FAIL after_reset_mid got=%b exp=00000", {grant_a, valid_a});
    else passed++;
  endtask

  task automatic test_fixed_prio();
    req_b = 4'b0010;
    tick();
    total++;
    if ({grant_b, idx_b} !== {4'b0010, 2'd1}) $display("FAIL fp_first got=%b/%0d exp=0010/1", grant_b, idx_b);
    else passed++;
    req_b = 4'b1110; done_b = 1'b1;
    tick();
    total++;
    if ({grant_b, valid_b, idx_b} !== {4'b0100, 1'b1, 2'd2}) $display("FAIL fp_excl got=%b/%0d exp=0100/2", grant_b, idx_b);
    else passed++;
    req_b = 4'b0110; done_b = 1'b1;
    tick();
    total++;
    if ({grant_b, idx_b} !== {4'b0010, 2'd1}) $display("FAIL fp_back got=%b/%0d exp=0010/1", grant_b, idx_b);
    else passed++;
    req_b = 4'b0011; done_b = 1'b0;
    tick();
    total++;
    if ({grant_b, idx_b} !== {4'b0010, 2'd1}) $display("FAIL fp_no_preempt got=%b/%0d exp=0010/1", grant_b, idx_b);
    else passed++;
    req_b = 4'b0000;
    tick();
    total++;
    if ({grant_b, valid_b, idx_b} !== 7'b0) $display("FAIL fp_idle got=%b exp=0000000", {grant_b, valid_b, idx_b});
    else passed++;
  endtask

  task automatic test_single();
    req_a = 4'b0100; done_a = 1'b0;
    tick();
    total++;
    if ({grant_a, valid_a, idx_a} !== {4'b0100, 1'b1, 2'd2}) $display("FAIL single_grant got=%b/%0d exp=0100/2", grant_a, idx_a);
    else passed++;
    done_a = 1'b1;
    tick();
    total++;
    if ({grant_a, valid_a} !== 5'b0) $display("FAIL single_gap got=%b exp=00000", {grant_a, valid_a});
    else passed++;
    done_a = 1'b0;
    tick();
    total++;
    if ({grant_a, idx_a} !== {4'b0100, 2'd2}) $display("FAIL single_regrant got=%b/%0d exp=0100/2", grant_a, idx_a);
    else passed++;
    req_a = 4'b0000;
    tick();
    total++;
    if ({grant_a, valid_a, idx_a} !== 7'b0) $display("FAIL req_drop_release got=%b exp=0000000", {grant_a, valid_a, idx_a});
    else passed++;
    done_a = 1'b1;
    tick();
    total++;
    if ({grant_a, valid_a} !== 5'b0) $display("FAIL done_idle got=%b exp=00000", {grant_a, valid_a});
    else passed++;
    done_a = 1'b0;
  endtask

  task automatic test_hold();
    // Pointer sits at 3 after lane 2 was granted, so the search 3,0 picks lane 0.
    req_a = 4'b0011; done_a = 1'b0;
    tick();
    total++;
    if ({grant_a, tmo_a} !== {4'b0001, 1'b0}) $display("FAIL hold_start got=%b/%b exp=0001/0", grant_a, tmo_a);
    else passed++;
`ifdef ARB_HOLD_LIMIT_EN
    for (int c = 1; c < 8; c++) begin
      tick();
      total++;
      if ({grant_a, tmo_a} !== {4'b0001, 1'b0}) $display("FAIL hold_keep cyc=%0d got=%b/%b exp=0001/0", c, grant_a, tmo_a);
      else passed++;
    end
    tick();
    total++;
    if ({grant_a, idx_a, tmo_a} !== {4'b0010, 2'd1, 1'b1}) $display("FAIL hold_timeout got=%b/%0d/%b exp=0010/1/1", grant_a, idx_a, tmo_a);
    else passed++;
    tick();
    total++;
    if ({grant_a, tmo_a} !== {4'b0010, 1'b0}) $display("FAIL hold_pulse_end got=%b/%b exp=0010/0", grant_a, tmo_a);
    else passed++;
`else
    for (int c = 1; c < 13; c++) begin
      tick();
      total++;
      if ({grant_a, tmo_a} !== {4'b0001, 1'b0}) $display("FAIL hold_forever cyc=%0d got=%b/%b exp=0001/0", c, grant_a, tmo_a);
      else passed++;
    end
`endif
    req_a = 4'b0000;
    tick();
    total++;
    if ({grant_a, valid_a} !== 5'b0) $display("FAIL hold_end got=%b exp=00000", {grant_a, valid_a});
    else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_rr_rotation();
    test_rr_wrap();
    test_reset_mid();
    test_fixed_prio();
    test_single();
    test_hold();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
